ps2_host_tx: RTL

Host-to-device PS/2 transmitter: the send-side counterpart of the keyboard receive path. It accepts one command byte per handshake (e.g. 0xED set-LEDs, 0xFF reset) and drives it onto the open-drain PS/2 clock and data lines using the host request-to-send protocol. It shifts bits on device-generated clock edges, appends odd parity and stop, and checks the device acknowledge. It sits beside `ps2_keyboard` on the same physical pins; the receiver must ignore the bus while `tx_ready` is low.

---
 rtl/ps2_host_tx.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/ps2_host_tx.sv
// ps2_host_tx -- host-to-device PS/2 transmitter.
//
// Sends one command byte per tx_valid/tx_ready handshake to a PS/2 device. The
// sequence is: inhibit the clock, request-to-send (pull data low), release the
// clock, then shift start/data/parity/stop on the device's falling clock edges.
// Finally the device acknowledge is sampled on the 11th edge.
// The pins are open-drain: an *_oe output of 1 pulls the line low.
//
// Ports:
//   clk, clrn              system clock, asynchronous active-low reset
//   tx_data, tx_valid      command byte and send request (sampled on accept)
//   tx_ready               high only while idle; accept = tx_valid & tx_ready
//   ps2_clk_in/data_in     raw pin levels (synchronized here)
//   ps2_clk_oe/data_oe     1 = pull the line low, 0 = release
//   done, ack_err          completion pulse; ack_err valid with done
//   timeout                abort pulse (no done for that transfer)
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       done,
    output logic       ack_err,
    output logic       timeout
);

    // One shared counter times inhibit, RTS and the transfer timeout.
    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                           ? ((TIMEOUT_CYCLES > 16) ? TIMEOUT_CYCLES : 16)
                           : ((INHIBIT_CYCLES > 16) ? INHIBIT_CYCLES : 16);
    localparam int CW = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
    localparam logic [CW-1:0] RTS_LAST = CW'(15);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        RTS,
        SEND,
        WAIT_IDLE
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [3:0]      n;
    logic [7:0]      data_q;
    logic            ack_pend;
    logic [2:0]      cs;
    logic [2:0]      ds;
    logic            clk_fall;

    assign clk_fall = cs[2] & ~cs[1];

    // Only ds[1] is used as the data sample; the third data flop mirrors the
    // clock path so both pins see identical synchronizer depth.
    logic unused_ds2;
    assign unused_ds2 = ds[2];

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state       <= IDLE;
            cnt         <= '0;
            n           <= '0;
            data_q      <= '0;
            ack_pend    <= 1'b0;
            cs          <= 3'b111;   // idle bus reads high; avoids a false edge
            ds          <= 3'b111;
            tx_ready    <= 1'b1;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            done        <= 1'b0;
            ack_err     <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            cs      <= {cs[1:0], ps2_clk_in};
            ds      <= {ds[1:0], ps2_data_in};
            done    <= 1'b0;
            ack_err <= 1'b0;
            timeout <= 1'b0;

            case (state)
                IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (tx_valid && tx_ready) begin
                        data_q     <= tx_data;
                        cnt        <= '0;
                        tx_ready   <= 1'b0;
                        ps2_clk_oe <= 1'b1;
                        state      <= INHIBIT;
                    end else begin
                        // First IDLE cycle after done/timeout keeps ready low.
                        tx_ready <= 1'b1;
                    end
                end

                // Edges seen here and in RTS come from our own clock pull-down.
                INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt         <= '0;
                        ps2_data_oe <= 1'b1;
                        state       <= RTS;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                RTS: begin
                    if (cnt == RTS_LAST) begin
                        cnt        <= '0;
                        n          <= '0;
                        ps2_clk_oe <= 1'b0;   // data stays low: start bit
                        state      <= SEND;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end

                SEND: begin
                    // Timeout is checked first so it wins over a final edge.
                    if (cnt == TO_LAST) begin
                        ps2_clk_oe  <= 1'b0;
                        ps2_data_oe <= 1'b0;
                        timeout     <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (clk_fall) begin
                            n <= n + 4'd1;
                            if (n < 4'd8) begin
                                ps2_data_oe <= ~data_q[n[2:0]];
                            end else if (n == 4'd8) begin
                                ps2_data_oe <= ^data_q;   // ~(odd parity bit)
                            end else if (n == 4'd9) begin
                                ps2_data_oe <= 1'b0;      // stop bit
                            end else begin
                                ps2_data_oe <= 1'b0;
                                ack_pend    <= ds[1];     // high = no ack
                                state       <= WAIT_IDLE;
                            end
                        end
                    end
                end

                WAIT_IDLE: begin
                    ps2_clk_oe  <= 1'b0;
                    ps2_data_oe <= 1'b0;
                    if (cnt == TO_LAST) begin
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                        if (cs[1] && ds[1]) begin
                            done    <= 1'b1;
                            ack_err <= ack_pend;
                            state   <= IDLE;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
